// File: rtl/csr_counter_bank.sv
// Machine counter bank: cycle (0), instret (2) and event counters (3..N-1) with their
// CSR decode, mcountinhibit and per-counter mhpmevent selectors.
module csr_counter_bank #(
    parameter int unsigned NUM_COUNTERS = 8,
    parameter int unsigned NUM_EVENTS   = 4,
    parameter int unsigned CNT_W        = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [11:0]             addr,
    input  logic [2:0]              f3,
    input  logic [4:0]              rs,
    input  logic [31:0]             reg_in,
    input  logic [31:0]             imm_in,
    input  logic                    write,
    input  logic                    retire,
    input  logic [NUM_EVENTS-1:0]   events,
    output logic [31:0]             reg_out,
    output logic                    hit,
    output logic                    illegal,
    output logic [NUM_COUNTERS-1:0] ovf
);
    localparam int unsigned SEL_W = 4;

    logic [CNT_W-1:0]        cnt_q [NUM_COUNTERS];
    logic [CNT_W-1:0]        cnt_d [NUM_COUNTERS];
    logic [SEL_W-1:0]        evt_q [NUM_COUNTERS];
    logic [SEL_W-1:0]        evt_d [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0] inh_q, inh_d;
    logic [NUM_COUNTERS-1:0] ovf_q, ovf_d;

    logic [NUM_COUNTERS-1:0] lo_sel, hi_sel, evt_sel, inc;
    logic                    inh_sel;
    logic [31:0]             src, wval;
    logic                    suppress, wr_en;

    // Counter 1 has no CSR: its selects stay 0 so it never hits or changes.
    always_comb begin
        lo_sel  = '0;
        hi_sel  = '0;
        evt_sel = '0;
        inh_sel = (addr == 12'h320);
        for (int n = 0; n < NUM_COUNTERS; n++) begin
            if (n != 1) begin
                lo_sel[n] = (addr == 12'hB00 + 12'(n));
                hi_sel[n] = (addr == 12'hB80 + 12'(n));
            end
            if (n >= 3) begin
                evt_sel[n] = (addr == 12'h323 + 12'(n - 3));
            end
        end
    end

    assign hit     = (|lo_sel) | (|hi_sel) | (|evt_sel) | inh_sel;
    assign illegal = !hit;

    always_comb begin
        reg_out = '0;
        for (int n = 0; n < NUM_COUNTERS; n++) begin
            if (lo_sel[n])  reg_out = cnt_q[n][31:0];
            if (hi_sel[n])  reg_out = 32'(cnt_q[n][CNT_W-1:32]);
            if (evt_sel[n]) reg_out = 32'(evt_q[n]);
        end
        if (inh_sel) reg_out = 32'(inh_q);
    end

    assign src      = f3[2] ? imm_in : reg_in;
    // Set/clear with a zero source is a pure read.
    assign suppress = f3[1] && (f3[2] ? (imm_in == '0) : (rs == '0));
    assign wr_en    = write && hit && !suppress && (f3[1:0] != 2'b00);

    always_comb begin
        wval = reg_out;
        case (f3[1:0])
            2'b01:   wval = src;
            2'b10:   wval = reg_out | src;
            2'b11:   wval = reg_out & ~src;
            default: wval = reg_out;
        endcase
    end

    always_comb begin
        inc    = '0;
        inc[0] = 1'b1;
        inc[2] = retire;
        for (int n = 3; n < NUM_COUNTERS; n++) begin
            for (int k = 0; k < NUM_EVENTS; k++) begin
                if (evt_q[n] == SEL_W'(k + 1) && events[k]) inc[n] = 1'b1;
            end
        end
        inc = inc & ~inh_q;
    end

    always_comb begin
        inh_d = inh_q;
        ovf_d = '0;
        if (wr_en && inh_sel) begin
            inh_d    = wval[NUM_COUNTERS-1:0];
            inh_d[1] = 1'b0;
        end
        for (int n = 0; n < NUM_COUNTERS; n++) begin
            cnt_d[n] = cnt_q[n];
            evt_d[n] = evt_q[n];
            // A CSR write to either half wins over that cycle's increment.
            if (wr_en && lo_sel[n]) begin
                cnt_d[n][31:0] = wval;
            end else if (wr_en && hi_sel[n]) begin
                cnt_d[n][CNT_W-1:32] = wval[CNT_W-33:0];
            end else if (inc[n]) begin
                cnt_d[n] = cnt_q[n] + CNT_W'(1);
                ovf_d[n] = &cnt_q[n];
            end
            if (wr_en && evt_sel[n]) begin
                evt_d[n] = (wval != '0 && wval <= 32'(NUM_EVENTS)) ? wval[SEL_W-1:0] : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < NUM_COUNTERS; n++) begin
                cnt_q[n] <= '0;
                evt_q[n] <= '0;
            end
            inh_q <= '0;
            ovf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            evt_q <= evt_d;
            inh_q <= inh_d;
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;

endmodule

// File: doc/csr_counter_bank.md
CSR_COUNTER_BANK -- requirements
Module: csr_counter_bank

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 SHALL take parameters, one per line:
- NUM_COUNTERS, 8, counter slots 0..NUM_COUNTERS-1, legal 3..32.
- NUM_EVENTS, 4, event inputs, legal 1..15.
- CNT_W, 64, counter width, legal 33..64.
REQ-003 SHALL have ports, one per line:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- addr  in  12  CSR address
- f3  in  3  CSR funct3
- rs  in  5  rs1 index
- reg_in  in  32  rs1 value
- imm_in  in  32  zero-extended uimm
- write  in  1  commit strobe for the CSR instruction
- retire  in  1  one instruction retired this cycle
- events  in  NUM_EVENTS  per-cycle event pulses
- reg_out  out  32  read data (combinational)
- hit  out  1  addr decodes to a register in this bank
- illegal  out  1  access illegal
- ovf  out  NUM_COUNTERS  one-cycle overflow pulses

Function
REQ-004 SHALL decode:
- 0xB00+n: counter n, low 32 bits.
- 0xB80+n: counter n, bits CNT_W-1:32, zero-extended.
- 0x320: mcountinhibit.
- 0x323+(n-3): mhpmevent n.
- n=1 (0xB01/0xB81) SHALL NOT hit.
REQ-005 SHALL form the source operand from f3[2]: 1 selects imm_in, 0 selects reg_in.
REQ-006 SHALL form the new value from f3[1:0]: 01 write, 10 old|src, 11 old&~src.
REQ-007 SHALL suppress the write when f3[1]=1 and the source is zero (imm_in==0 or rs==0); reads still occur.
REQ-008 SHALL assert illegal = !hit.
REQ-009 SHALL update state only when write && !illegal && write not suppressed.
REQ-010 SHALL increment counter 0 by 1 each cycle unless inhibited.
REQ-011 SHALL increment counter 2 on each retire cycle unless inhibited.
REQ-012 SHALL increment counter n>=3 when its selected event input is 1 and the counter is not inhibited.
REQ-013 SHALL implement mcountinhibit bits NUM_COUNTERS-1:0 with bit 1 hardwired 0; all other bits read 0.
REQ-014 SHALL treat mhpmevent as WARL: 0 counts nothing, k in 1..NUM_EVENTS selects events[k-1], any other written value stores 0.
REQ-015 SHALL, on a CSR write to a counter half in a cycle, load that half with the written value, hold the other half, and drop that cycle's increment.
REQ-016 SHALL count modulo 2^CNT_W.
REQ-017 SHALL pulse ovf[n] for exactly one cycle, in the cycle after an increment carries counter n from all-ones to 0.
REQ-018 SHALL NOT pulse ovf when a CSR write produces 0.
REQ-019 SHALL apply a write to mcountinhibit from the next cycle; the increment in the write cycle uses the old inhibit.
REQ-020 SHALL return 0 on reg_out when hit=0.

Reset
REQ-021 SHALL, while rst=1, set all counters, mcountinhibit, mhpmevent and ovf to 0, with no increments during that cycle.
REQ-022 SHALL ignore write, retire and events while rst=1, including a reset asserted in the middle of counting.

Verification
REQ-023 Reset, then 10 idle cycles, then read 0xB00 -> reg_out=10; read 0xB02 -> 0.
REQ-024 Write 0xFFFFFFFF to 0xB02 and 0xFFFFFFFF to 0xB82 (CNT_W=64), pulse retire once -> counter reads 0, ovf[2] high for exactly one cycle.
REQ-025 Write 2 to 0x323, drive events=4'b0010 for 5 cycles and events[0] for 3 cycles -> 0xB03 reads 5; with 0x323 written 9 -> 0x323 reads 0 and the counter holds.
REQ-026 csrrs (f3=010) with rs=0 on 0xB00 -> no write, current count returned, illegal=0; csrrw to 0xB01 -> illegal=1, no state change.
REQ-027 csrrsi uimm=1 to 0x320 -> cycle counter frozen from the next cycle, read 0x320 -> 1; writing 0x002 to 0x320 -> reads 0.
REQ-028 Write 0x100 to 0xB00 in the same cycle counting is active -> next read 0x100, then 0x101.
